alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational RV32I ALU instance between two requesters (req 0: EX stage,
//  req 1: auxiliary address/branch unit). Round-robin grant; operands and result registered;
//  valid/ready handshake on both request and response sides. Sits beside the EX stage.
// PARAMETERS
//  XLEN   32  operand/result width
//  OPW    4   ALU op-code width (encodings in define.vh)
// PORTS
//  clk            in   1       single clock, rising edge
//  rst_n          in   1       asynchronous, active-low reset
//  req_valid[i]   in   1       i=0,1: request present
//  req_ready[i]   out  1       request accepted this cycle when valid&ready
//  req_op[i]      in   OPW     ALU op code
//  req_a[i]       in   XLEN    operand 1 (data1)
//  req_b[i]       in   XLEN    operand 2 (data2; shifts use [4:0])
//  rsp_valid[i]   out  1       result available for requester i
//  rsp_ready[i]   in   1       requester i consumes result
//  rsp_data       out  XLEN    result, shared bus, meaningful where rsp_valid[i]=1
//  alu_op         out  OPW     to shared ALU
//  alu_data1      out  XLEN    to shared ALU
//  alu_data2      out  XLEN    to shared ALU
//  alu_result     in   XLEN    from shared ALU (combinational)
// BEHAVIOUR
//  - FSM: IDLE, EXEC, RESP. Reset -> IDLE, prio=0, owner=0, all outputs 0 (alu_* = 0).
//  - req_ready[i] combinational: 1 only for the granted requester in IDLE, or in RESP on the
//    cycle the owner's response handshakes. Never both set. Never set in EXEC.
//  - Grant: if only one valid, grant it; if both, grant req[prio].
//  - Accept (valid&ready): latch op/a/b/owner into issue regs; next state EXEC.
//  - EXEC (1 cycle): alu_* driven from issue regs; alu_result captured into rsp_data;
//    rsp_valid[owner]<=1; -> RESP. alu_* hold issue regs in all states (no glitch to 0).
//  - RESP: rsp_valid[owner] and rsp_data held stable until rsp_ready[owner].
//    On handshake: rsp_valid<=0; prio<=~owner; if a request is pending, same-cycle accept
//    with grant computed using the updated prio (non-owner wins ties) -> EXEC; else -> IDLE.
//  - Latency: accept at edge T -> rsp_valid=1 after edge T+2. Back-to-back throughput:
//    one op per 2 cycles when rsp_ready is held high.
//  - req_* must be held stable while valid&!ready; arbiter does not check.
//  - rsp_ready of non-owner ignored. rsp_ready while rsp_valid=0 ignored.
//  - Undefined op codes passed through unchanged; ALU yields 0, returned as result.
//  - Arithmetic/width: none performed here; data passed XLEN bits verbatim, signedness
//    is the ALU's concern.
//  - Starvation bound: a held request is accepted within one other transaction.
//  - rst_n assertion mid-transaction: in-flight op and pending response discarded,
//    no rsp_valid after release; first grant after release favours req 0.
// STRUCTURE
//  - ALU op-code constants (ALU_ADD=4'b0000, SUB=1000, SLL=0001, SLT=0010, SLTU=0011,
//    XOR=0100, SRL=0101, SRA=1101, OR=0110, AND=0111) and FSM state encodings in define.vh.
//  - One sub-module: rr_arb2 (2-way combinational grant from valid[1:0], prio).
//  - ALU instantiated outside; this block only drives/observes its ports.
// TESTING
//  1 req0 ADD a=5 b=7 alone -> req_ready0=1 at T, rsp_valid0=1 at T+2, rsp_data=12.
//  2 req0 and req1 together after reset (req0 SUB 3-5, req1 SRA 0x80000000>>4) ->
//    req0 first, rsp=0xFFFFFFFE; then req1 granted on its handshake, rsp=0xF8000000.
//  3 Both held valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; op every 2 cycles.
//  4 rsp_ready1 low 5 cycles with SLTU a=1 b=0xFFFFFFFF -> rsp_valid1 and rsp_data=1 held
//    stable, req_ready0/1=0 throughout; req0 accepted on the release cycle.
//  5 rst_n pulsed low during EXEC -> all outputs 0 asynchronously, no response after
//    release; next simultaneous request grants req0.
//  6 Undefined op 4'b1111 a=9 b=9 -> rsp_data=0, normal handshake timing.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU sharing arbiter.
package alu_share_arbiter_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 4;

  // RV32I ALU op codes understood by the shared ALU.
  localparam logic [OPW-1:0] AluAdd  = 4'b0000;
  localparam logic [OPW-1:0] AluSub  = 4'b1000;
  localparam logic [OPW-1:0] AluSll  = 4'b0001;
  localparam logic [OPW-1:0] AluSlt  = 4'b0010;
  localparam logic [OPW-1:0] AluSltu = 4'b0011;
  localparam logic [OPW-1:0] AluXor  = 4'b0100;
  localparam logic [OPW-1:0] AluSrl  = 4'b0101;
  localparam logic [OPW-1:0] AluSra  = 4'b1101;
  localparam logic [OPW-1:0] AluOr   = 4'b0110;
  localparam logic [OPW-1:0] AluAnd  = 4'b0111;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StResp = 2'b10
  } state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response handshake bundle for both ALU requesters (index 0: EX, 1: aux unit).
interface alu_share_arbiter_if;

  logic [1:0]                                    req_valid;
  logic [1:0]                                    req_ready;
  logic [1:0][alu_share_arbiter_pkg::OPW-1:0]    req_op;
  logic [1:0][alu_share_arbiter_pkg::XLEN-1:0]   req_a;
  logic [1:0][alu_share_arbiter_pkg::XLEN-1:0]   req_b;
  logic [1:0]                                    rsp_valid;
  logic [1:0]                                    rsp_ready;
  logic [alu_share_arbiter_pkg::XLEN-1:0]        rsp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way combinational grant: a lone requester wins, ties go to prio_i.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       prio_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (valid_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = prio_i ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU between two requesters,
// with registered operands/result and valid/ready on both sides.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus,
  output logic [OPW-1:0]      alu_op_o,
  output logic [XLEN-1:0]     alu_data1_o,
  output logic [XLEN-1:0]     alu_data2_o,
  input  logic [XLEN-1:0]     alu_result_i
);

  state_e          state_q, state_d;
  logic            prio_q, prio_d;
  logic            owner_q, owner_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [1:0]      rsp_valid_q, rsp_valid_d;
  logic [1:0]      gnt;
  logic [1:0]      req_ready;
  logic            arb_prio;
  logic            accept;

  // In RESP the grant already uses the post-handshake priority, so the non-owner wins ties.
  assign arb_prio = (state_q == StResp) ? ~owner_q : prio_q;

  rr_arb2 u_rr_arb2 (
    .valid_i (bus.req_valid),
    .prio_i  (arb_prio),
    .gnt_o   (gnt)
  );

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    data_d      = data_q;
    rsp_valid_d = rsp_valid_q;
    req_ready   = 2'b00;
    accept      = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = gnt;
        accept    = |gnt;
      end
      StExec: begin
        data_d               = alu_result_i;
        rsp_valid_d[owner_q] = 1'b1;
        state_d              = StResp;
      end
      StResp: begin
        if (bus.rsp_ready[owner_q]) begin
          rsp_valid_d = 2'b00;
          prio_d      = ~owner_q;
          req_ready   = gnt;
          accept      = |gnt;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      owner_d = gnt[1];
      op_d    = bus.req_op[gnt[1]];
      a_d     = bus.req_a[gnt[1]];
      b_d     = bus.req_b[gnt[1]];
      state_d = StExec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      data_q      <= '0;
      rsp_valid_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Ready is masked during reset so nothing appears accepted while the block is held.
  assign bus.req_ready = req_ready & {2{rst_n}};
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = data_q;
  assign alu_op_o      = op_q;
  assign alu_data1_o   = a_q;
  assign alu_data2_o   = b_q;

endmodule
